// File: rtl/relay_sequencer.sv
// relay_sequencer: validates relay words from the SDI stage and applies them break-before-make.
// Optional watchdog that opens all relays after a silent period: define RELAY_WATCHDOG_EN.
module relay_sequencer #(
  parameter int NBITS        = 24,
  parameter int MAX_CLOSED   = 2,
  parameter int BREAK_CYCLES = 4,
  parameter int MAKE_CYCLES  = 4,
  parameter int WDOG_CYCLES  = 1000
) (
  input  logic             CLK_SYS,
  input  logic             RESET,
  input  logic [NBITS-1:0] DATA_IN,
  input  logic             DATA_READY,
  output logic [NBITS-1:0] RELAYS,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR
);
  localparam int CMAX0 = (BREAK_CYCLES > MAKE_CYCLES) ? BREAK_CYCLES : MAKE_CYCLES;
  localparam int CMAX  = (CMAX0 > WDOG_CYCLES) ? CMAX0 : WDOG_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAKE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] relays_q, relays_d, target_q, target_d, pend_q, pend_d;
  logic             pend_v_q, pend_v_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [NBITS-1:0] word;
  logic             have_word;
  logic             wd_fire;

  function automatic int popcount(input logic [NBITS-1:0] w);
    int n;
    n = 0;
    for (int i = 0; i < NBITS; i++) n += int'(w[i]);
    return n;
  endfunction

`ifdef RELAY_WATCHDOG_EN
  logic [CW-1:0] wd_q, wd_d;

  // Saturates at WDOG_CYCLES so one silent period fires exactly once.
  always_comb begin
    wd_fire = 1'b0;
    if (DATA_READY) begin
      wd_d = '0;
    end else if (wd_q == CW'(WDOG_CYCLES)) begin
      wd_d = wd_q;
    end else begin
      wd_d    = wd_q + CW'(1);
      wd_fire = (wd_q == CW'(WDOG_CYCLES - 1));
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (RESET) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign word      = DATA_READY ? DATA_IN : pend_q;
  assign have_word = DATA_READY | pend_v_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relays_d = relays_q;
    target_d = target_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A fresh strobe wins over the pending word, which is dropped either way.
        pend_v_d = 1'b0;
        if (have_word) begin
          if (popcount(word) > MAX_CLOSED) begin
            relays_d = '0;
            err_d    = 1'b1;
            done_d   = 1'b1;
          end else if (word == relays_q) begin
            err_d  = 1'b0;
            done_d = 1'b1;
          end else if ((relays_q & ~word) == '0) begin
            relays_d = word;
            target_d = word;
            err_d    = 1'b0;
            cnt_d    = '0;
            state_d  = S_MAKE;
          end else begin
            relays_d = relays_q & word;
            target_d = word;
            err_d    = 1'b0;
            cnt_d    = '0;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (cnt_q == CW'(BREAK_CYCLES - 1)) begin
          relays_d = target_q;
          cnt_d    = '0;
          state_d  = S_MAKE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MAKE: begin
        if (cnt_q == CW'(MAKE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && DATA_READY) begin
      pend_d   = DATA_IN;
      pend_v_d = 1'b1;
    end

    if (wd_fire) begin
      relays_d = '0;
      err_d    = 1'b1;
      pend_v_d = 1'b0;
      cnt_d    = '0;
      state_d  = S_IDLE;
      done_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK_SYS) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      relays_q <= '0;
      target_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      relays_q <= relays_d;
      target_q <= target_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign RELAYS = relays_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign ERROR  = err_q;
endmodule
